// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding,
// control opcodes, instruction field positions and the fixed memory depth.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int WORD_W = 18;

    localparam logic [3:0] OP_JUMP = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB  = 17;
    localparam int OP_LSB  = 14;
    localparam int R1_MSB  = 13;
    localparam int R1_LSB  = 11;
    localparam int R2_MSB  = 10;
    localparam int R2_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Highest valid memory index; lastIndex values above this are pulled down to it.
    localparam logic [3:0] MEM_LAST = 4'd9;

    function automatic logic [3:0] clamp_last(input logic [3:0] idx);
        return (idx > MEM_LAST) ? MEM_LAST : idx;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational split of an 18-bit instruction word into opcode,
// two register IDs and an 8-bit immediate, plus jump/halt flags.
module instr_decode
    import seq_pkg::*;
(
    input  logic [WORD_W-1:0] instr,
    output logic [3:0]        op_code,
    output logic [2:0]        reg_id1,
    output logic [2:0]        reg_id2,
    output logic [7:0]        imm,
    output logic              is_jump,
    output logic              is_halt
);

    assign op_code = instr[OP_MSB:OP_LSB];
    assign reg_id1 = instr[R1_MSB:R1_LSB];
    assign reg_id2 = instr[R2_MSB:R2_LSB];
    assign imm     = instr[IMM_MSB:IMM_LSB];
    assign is_jump = (op_code == OP_JUMP);
    assign is_halt = (op_code == OP_HALT);

endmodule

// File: rtl/program_sequencer.sv
// Walks the ten-entry instruction memory from index 0, resolves JUMP and HALT
// locally and issues all other instructions to the execute stage.
//
// Execute handshake: execValid and the exec fields are registered and held
// stable while execValid=1; the instruction is accepted on a rising clock edge
// where execValid=1 and execReady=1, and execValid drops in the next cycle.
//
// Optional build macro: SEQ_SINGLE_STEP_EN adds a 'step' input; FETCH then
// waits for a step pulse before latching the instruction.
module program_sequencer
    import seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [3:0]  lastIndex,
    input  logic [17:0] instrIn,
    input  logic        execReady,
    output logic [3:0]  pc,
    output logic        execValid,
    output logic [3:0]  execOpCode,
    output logic [2:0]  execRegID1,
    output logic [2:0]  execRegID2,
    output logic [7:0]  execImm,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);

    state_t      state;
    logic [17:0] ir;
    logic [3:0]  last_clamped;
    logic [3:0]  jump_target;
    logic        fetch_go;

    logic [3:0]  dec_op;
    logic [2:0]  dec_r1;
    logic [2:0]  dec_r2;
    logic [7:0]  dec_imm;
    logic        dec_jump;
    logic        dec_halt;

    instr_decode u_decode (
        .instr   (ir),
        .op_code (dec_op),
        .reg_id1 (dec_r1),
        .reg_id2 (dec_r2),
        .imm     (dec_imm),
        .is_jump (dec_jump),
        .is_halt (dec_halt)
    );

    assign last_clamped = clamp_last(lastIndex);
    assign jump_target  = dec_imm[3:0];
    assign state_dbg    = state;

`ifdef SEQ_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Sequencer FSM; all outputs are registered and updated alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= 4'd0;
            ir         <= '0;
            execValid  <= 1'b0;
            execOpCode <= 4'd0;
            execRegID1 <= 3'd0;
            execRegID2 <= 3'd0;
            execImm    <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else if (abort) begin
            // Abort wins over everything, including a pending handshake.
            state     <= IDLE;
            pc        <= 4'd0;
            execValid <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= FETCH;
                        pc    <= 4'd0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (fetch_go) begin
                        ir    <= instrIn;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_halt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (dec_jump) begin
                        if (jump_target > last_clamped) begin
                            error <= 1'b1;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pc    <= jump_target;
                            state <= FETCH;
                        end
                    end else begin
                        execValid  <= 1'b1;
                        execOpCode <= dec_op;
                        execRegID1 <= dec_r1;
                        execRegID2 <= dec_r2;
                        execImm    <= dec_imm;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (execReady) begin
                        execValid <= 1'b0;
                        // >= keeps pc in range even if lastIndex shrinks mid-run.
                        if (pc >= last_clamped) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pc    <= pc + 4'd1;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pc        <= 4'd0;
                    execValid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: expected issues are queued at stimulus
// time and a negedge monitor pops and compares every accepted instruction.
module tb_program_sequencer;
    import seq_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [3:0]  lastIndex;
    logic [17:0] instrIn;
    logic        execReady;
    logic [3:0]  pc;
    logic        execValid;
    logic [3:0]  execOpCode;
    logic [2:0]  execRegID1;
    logic [2:0]  execRegID2;
    logic [7:0]  execImm;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  state_dbg;

    logic [17:0] mem [10];
    logic [21:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int last_hs  = -1;
    bit check_interval = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cycle++;
        end
    end

    assign instrIn = (pc < 4'd10) ? mem[pc] : 18'h0;

`ifdef SEQ_SINGLE_STEP_EN
    logic step;
    int   step_period = 0;
    int   step_cnt    = 0;
    initial begin
        step = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (step_period == 0) begin
                step = 1'b1;
            end else begin
                step_cnt++;
                step = ((step_cnt % step_period) == 0);
            end
        end
    end
`endif

    program_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
`ifdef SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .lastIndex  (lastIndex),
        .instrIn    (instrIn),
        .execReady  (execReady),
        .pc         (pc),
        .execValid  (execValid),
        .execOpCode (execOpCode),
        .execRegID1 (execRegID1),
        .execRegID2 (execRegID2),
        .execImm    (execImm),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    // ---------------- check helper ----------------
    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [21:0] got;
        logic [21:0] hold_val;
        logic [21:0] exp;
        bit          hold_pending;
        hold_pending = 0;
        hold_val     = '0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && execValid === 1'b1) begin
                got = {pc, execOpCode, execRegID1, execRegID2, execImm};
                if (hold_pending)
                    check(got == hold_val, "hold_stable", 32'(got), 32'(hold_val));
                if (execReady) begin
                    hold_pending = 0;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_issue", 32'(got), 32'h0);
                    end else begin
                        exp = exp_q.pop_front();
                        check(got == exp, "issue", 32'(got), 32'(exp));
                        if (check_interval && last_hs >= 0)
                            check((cycle - last_hs) == 3, "issue_interval", 32'(cycle - last_hs), 32'd3);
                        last_hs = cycle;
                    end
                end else begin
                    hold_pending = 1;
                    hold_val     = got;
                end
            end else begin
                hold_pending = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clock); #1 abort = 1'b1;
        @(posedge clock); #1 abort = 1'b0;
    endtask

    task automatic expect_issue(input logic [3:0] p);
        exp_q.push_back({p, mem[p]});
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(done === 1'b1, name, 32'(done), 32'd1);
        check(exp_q.size() == 0, {name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (execValid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(execValid === 1'b1, name, 32'(execValid), 32'd1);
    endtask

    task automatic load_straight();
        for (int i = 0; i < 10; i++) mem[i] = 18'h0;
        mem[0] = 18'h0C1C0;
        mem[1] = 18'h08A05;
        mem[2] = 18'h10300;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        lastIndex = 4'd0;
        execReady = 1'b1;
        for (int i = 0; i < 10; i++) mem[i] = 18'h0;

        tick(3);
        check(pc == 4'd0, "reset_pc", 32'(pc), 32'd0);
        check(execValid == 1'b0, "reset_valid", 32'(execValid), 32'd0);
        check({execOpCode, execRegID1, execRegID2, execImm} == 18'h0, "reset_fields",
              32'({execOpCode, execRegID1, execRegID2, execImm}), 32'd0);
        check({busy, done, error} == 3'b000, "reset_flags", 32'({busy, done, error}), 32'd0);
        check(state_dbg == 3'(IDLE), "reset_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b1;
        tick(2);

`ifdef SEQ_SINGLE_STEP_EN
        // One issue per step pulse, spaced ten cycles apart.
        load_straight();
        lastIndex   = 4'd2;
        step_period = 10;
        step_cnt    = 1;
        expect_issue(4'd0); expect_issue(4'd1); expect_issue(4'd2);
        pulse_start();
        tick(12);
        check(exp_q.size() == 2, "step_one_issue", 32'(exp_q.size()), 32'd2);
        wait_done(60, "step_done");
        step_period = 0;
        tick(2);
`endif

        // Straight-line program, execReady high: three issues 3 cycles apart.
        load_straight();
        lastIndex      = 4'd2;
        check_interval = 1;
        last_hs        = -1;
        expect_issue(4'd0); expect_issue(4'd1); expect_issue(4'd2);
        pulse_start();
        check(busy == 1'b1, "straight_busy", 32'(busy), 32'd1);
        wait_done(40, "straight_done");
        check(error == 1'b0, "straight_error", 32'(error), 32'd0);
        check(busy == 1'b0, "straight_not_busy", 32'(busy), 32'd0);
        check_interval = 0;
        tick(2);

        // Backpressure on the first issue, with a start pulse ignored while busy.
        execReady = 1'b0;
        expect_issue(4'd0); expect_issue(4'd1); expect_issue(4'd2);
        pulse_start();
        wait_valid(10, "bp_valid");
        pulse_start();
        tick(4);
        check(pc == 4'd0, "bp_pc_held", 32'(pc), 32'd0);
        check(execValid == 1'b1, "bp_valid_held", 32'(execValid), 32'd1);
        execReady = 1'b1;
        wait_done(40, "bp_done");
        tick(2);

        // Jump from pc 1 to pc 3 with lastIndex 4: pc 1 and 2 never issue.
        for (int i = 0; i < 10; i++) mem[i] = 18'h0;
        mem[0] = 18'h0C1C0;
        mem[1] = 18'h38003;
        mem[2] = 18'h08A05;
        mem[3] = 18'h10300;
        mem[4] = 18'h04411;
        lastIndex = 4'd4;
        expect_issue(4'd0); expect_issue(4'd3); expect_issue(4'd4);
        pulse_start();
        wait_done(60, "jump_done");
        check(error == 1'b0, "jump_error", 32'(error), 32'd0);
        tick(2);

        // Out-of-range jump (7 > 4): done and error, nothing issued after it.
        mem[1] = 18'h38007;
        expect_issue(4'd0);
        pulse_start();
        wait_done(40, "badjump_done");
        check(error == 1'b1, "badjump_error", 32'(error), 32'd1);
        tick(3);
        check(error == 1'b1, "error_sticky", 32'(error), 32'd1);

        // Abort from DONE clears error and done.
        pulse_abort();
        check({done, error, busy} == 3'b000, "abort_clears", 32'({done, error, busy}), 32'd0);

        // HALT at pc 1: a single issue then done.
        mem[1] = 18'h3C000;
        expect_issue(4'd0);
        pulse_start();
        wait_done(40, "halt_done");
        check(error == 1'b0, "halt_error", 32'(error), 32'd0);
        tick(2);

        // lastIndex above 9 is clamped: all ten words issue.
        for (int i = 0; i < 10; i++) begin
            mem[i] = 18'h01000 + 18'(i);
            expect_issue(4'(i));
        end
        lastIndex = 4'd12;
        pulse_start();
        wait_done(80, "clamp_done");
        check(pc == 4'd9, "clamp_pc", 32'(pc), 32'd9);
        tick(2);

        // Abort in ISSUE with execReady low: instruction dropped, back to IDLE.
        load_straight();
        lastIndex = 4'd2;
        execReady = 1'b0;
        pulse_start();
        wait_valid(10, "abort_valid");
        pulse_abort();
        check(execValid == 1'b0, "abort_valid_low", 32'(execValid), 32'd0);
        check(pc == 4'd0, "abort_pc", 32'(pc), 32'd0);
        check(state_dbg == 3'(IDLE), "abort_state", 32'(state_dbg), 32'(IDLE));
        execReady = 1'b1;
        tick(2);

        // Asynchronous reset mid-run: outputs drop without waiting for an edge.
        execReady = 1'b0;
        pulse_start();
        wait_valid(10, "reset_run_valid");
        #2 reset = 1'b0;
        #1;
        check({pc, execValid, busy, done, error} == 8'h0, "async_reset_outputs",
              32'({pc, execValid, busy, done, error}), 32'd0);
        check({execOpCode, execRegID1, execRegID2, execImm} == 18'h0, "async_reset_fields",
              32'({execOpCode, execRegID1, execRegID2, execImm}), 32'd0);
        tick(2);
        reset     = 1'b1;
        execReady = 1'b1;
        tick(1);

        // Restart after reset begins again at pc 0.
        expect_issue(4'd0); expect_issue(4'd1); expect_issue(4'd2);
        pulse_start();
        wait_done(40, "restart_done");
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
